// File: rtl/serie_paralelo_align_if.sv
// Lane receive bus: enable and serial bit toward the deserializer, aligned
// byte stream and lock status back out of it.
interface serie_paralelo_align_if;
   logic       enb;
   logic       serial_in;
   logic [7:0] data_out;
   logic       valid_out;
   logic       active;
   logic       com_seen;

   // Driver side of the lane (serializer / test stimulus).
   modport master (
      output enb, serial_in,
      input  data_out, valid_out, active, com_seen
   );

   // Deserializer side.
   modport slave (
      input  enb, serial_in,
      output data_out, valid_out, active, com_seen
   );
endinterface

// File: rtl/serie_paralelo_align.sv
// Per-lane serial-to-parallel front end with COM-symbol byte alignment.
// Hunts COM at any bit offset, locks after COM_TO_LOCK aligned COMs, then
// forwards every aligned non-COM byte with a one-cycle valid strobe.
// Optional feature macro: SP_LOSS_OF_LOCK_EN (drop lock after LOSS_LIMIT
// consecutive non-COM bytes while aligned).
module serie_paralelo_align #(
   parameter logic [7:0] COM         = 8'hBC,
   parameter int         COM_TO_LOCK = 4,
   parameter int         LOSS_LIMIT  = 16
) (
   input logic                   clk,
   input logic                   reset,
   serie_paralelo_align_if.slave bus
);

   localparam logic [3:0] LOCK_N = 4'(COM_TO_LOCK);

   typedef enum logic [1:0] {SEARCH, LOCKING, ALIGNED} state_t;

   state_t     state_reg, state_next;
   logic [7:0] sreg_reg, sreg_next;
   logic [2:0] bit_cnt_reg, bit_cnt_next;
   logic [3:0] com_cnt_reg, com_cnt_next;
   logic [7:0] data_reg, data_next;
   logic       valid_reg, valid_next;
   logic       seen_reg, seen_next;

`ifdef SP_LOSS_OF_LOCK_EN
   localparam logic [4:0] LOSS_N = 5'(LOSS_LIMIT);
   logic [4:0] miss_reg, miss_next;
`endif

   wire boundary = (bit_cnt_reg == 3'd0);
   wire is_com   = (sreg_reg == COM);

   // State and datapath registers; everything holds while enb is low
   // because the next-state logic then returns current values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= SEARCH;
         sreg_reg    <= 8'd0;
         bit_cnt_reg <= 3'd0;
         com_cnt_reg <= 4'd0;
         data_reg    <= 8'd0;
         valid_reg   <= 1'b0;
         seen_reg    <= 1'b0;
`ifdef SP_LOSS_OF_LOCK_EN
         miss_reg    <= 5'd0;
`endif
      end else begin
         state_reg   <= state_next;
         sreg_reg    <= sreg_next;
         bit_cnt_reg <= bit_cnt_next;
         com_cnt_reg <= com_cnt_next;
         data_reg    <= data_next;
         valid_reg   <= valid_next;
         seen_reg    <= seen_next;
`ifdef SP_LOSS_OF_LOCK_EN
         miss_reg    <= miss_next;
`endif
      end
   end

   // Shift, alignment FSM and byte delivery.
   always_comb begin
      state_next   = state_reg;
      sreg_next    = sreg_reg;
      bit_cnt_next = bit_cnt_reg;
      com_cnt_next = com_cnt_reg;
      data_next    = data_reg;
      valid_next   = 1'b0;
      seen_next    = 1'b0;
`ifdef SP_LOSS_OF_LOCK_EN
      miss_next    = miss_reg;
`endif
      if (bus.enb) begin
         sreg_next    = {sreg_reg[6:0], bus.serial_in};
         bit_cnt_next = bit_cnt_reg + 3'd1;
         case (state_reg)
            SEARCH: begin
               // Sliding window: a COM at any offset sets the byte phase.
               if (is_com) begin
                  bit_cnt_next = 3'd1;
                  com_cnt_next = 4'd1;
                  state_next   = (COM_TO_LOCK == 1) ? ALIGNED : LOCKING;
               end
            end
            LOCKING: begin
               if (boundary) begin
                  if (is_com) begin
                     if (com_cnt_reg + 4'd1 == LOCK_N) begin
                        com_cnt_next = LOCK_N;
                        state_next   = ALIGNED;
                     end else begin
                        com_cnt_next = com_cnt_reg + 4'd1;
                     end
                  end else begin
                     com_cnt_next = 4'd0;
                     state_next   = SEARCH;
                  end
               end
            end
            ALIGNED: begin
               if (boundary) begin
                  if (is_com) begin
                     seen_next = 1'b1;
`ifdef SP_LOSS_OF_LOCK_EN
                     miss_next = 5'd0;
`endif
                  end else begin
                     data_next  = sreg_reg;
                     valid_next = 1'b1;
`ifdef SP_LOSS_OF_LOCK_EN
                     // The byte that exhausts the budget is still delivered.
                     if (miss_reg + 5'd1 == LOSS_N) begin
                        miss_next    = 5'd0;
                        com_cnt_next = 4'd0;
                        state_next   = SEARCH;
                     end else begin
                        miss_next = miss_reg + 5'd1;
                     end
`endif
                  end
               end
            end
            default: state_next = SEARCH;
         endcase
      end
   end

   assign bus.data_out  = data_reg;
   assign bus.valid_out = valid_reg & bus.enb;
   assign bus.com_seen  = seen_reg & bus.enb;
   assign bus.active    = (state_reg == ALIGNED);

endmodule

// File: tb/tb_serie_paralelo_align.sv
// Directed bench for serie_paralelo_align: lock, offset lock, lock restart,
// COM filtering, enable freeze, async reset, and optional loss of lock.
module tb_serie_paralelo_align;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serie_paralelo_align_if bus();

   serie_paralelo_align dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int vcnt  = 0;
   int scnt  = 0;
   int vcyc  = 0;

   // Pulse monitor, sampled on the falling edge.
   always @(negedge clk) begin
      cyc = cyc + 1;
      if (bus.valid_out === 1'b1) begin
         vcnt = vcnt + 1;
         vcyc = cyc;
      end
      if (bus.com_seen === 1'b1) scnt = scnt + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   task automatic tick_bit(input logic b);
      @(negedge clk); #1;
      bus.serial_in = b;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) tick_bit(b[i]);
   endtask

   task automatic lock4();
      for (int i = 0; i < 4; i++) send_byte(8'hBC);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      reset = 1'b1;
      bus.enb = 1'b1;
      bus.serial_in = 1'b0;
      @(negedge clk); #1;
      reset = 1'b0;
   endtask

   int vb, sb, start;

   initial begin
      reset = 1'b1;
      bus.enb = 1'b0;
      bus.serial_in = 1'b0;
      #1;
      chk("rst_data", bus.data_out, 8'h00);
      chk("rst_valid", bus.valid_out, 1'b0);
      chk("rst_active", bus.active, 1'b0);
      chk("rst_seen", bus.com_seen, 1'b0);

      // 4 aligned COMs then 12, 34
      do_reset();
      vb = vcnt; sb = scnt;
      lock4();
      chk("t1_active_before", bus.active, 1'b0);
      tick_bit(1'b0); tick_bit(1'b0);  // first bits of 12; lock boundary passes
      chk("t1_active_after", bus.active, 1'b1);
      start = cyc - 1;
      for (int i = 5; i >= 0; i--) tick_bit(1'(8'h12 >> i));
      chk("t1_no_valid_yet", 32'(vcnt - vb), 0);
      send_byte(8'h34);
      chk("t1_cnt1", 32'(vcnt - vb), 1);
      chk("t1_data12", bus.data_out, 8'h12);
      chk("t1_latency", 32'(vcyc - start), 9);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t1_cnt2", 32'(vcnt - vb), 2);
      chk("t1_data34", bus.data_out, 8'h34);
      chk("t1_seen", 32'(scnt - sb), 0);

      // 3 junk bits, then lock at that offset
      do_reset();
      vb = vcnt;
      tick_bit(1'b1); tick_bit(1'b0); tick_bit(1'b1);
      lock4();
      send_byte(8'hA5);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t2_active", bus.active, 1'b1);
      chk("t2_cnt", 32'(vcnt - vb), 1);
      chk("t2_data", bus.data_out, 8'hA5);

      // broken COM run restarts the lock count
      do_reset();
      vb = vcnt;
      send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h00);
      send_byte(8'hBC); send_byte(8'hBC); send_byte(8'hBC);
      chk("t3_active_3com", bus.active, 1'b0);
      send_byte(8'hBC);
      chk("t3_active_4com", bus.active, 1'b0);
      send_byte(8'h77);
      chk("t3_active_lock", bus.active, 1'b1);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t3_cnt", 32'(vcnt - vb), 1);
      chk("t3_data", bus.data_out, 8'h77);

      // COM inside aligned stream is never forwarded
      do_reset();
      lock4();
      vb = vcnt; sb = scnt;
      send_byte(8'hBC); send_byte(8'h55); send_byte(8'hBC);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t4_seen", 32'(scnt - sb), 2);
      chk("t4_valid", 32'(vcnt - vb), 1);
      chk("t4_data", bus.data_out, 8'h55);

      // enb low 5 cycles in the middle of C3
      do_reset();
      lock4();
      vb = vcnt;
      tick_bit(1'b1);
      start = cyc;
      tick_bit(1'b1); tick_bit(1'b0); tick_bit(1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); #1;
         bus.enb = 1'b0;
      end
      chk("t5_valid_frozen", bus.valid_out, 1'b0);
      @(negedge clk); #1;
      bus.enb = 1'b1;
      bus.serial_in = 1'b0;
      tick_bit(1'b0); tick_bit(1'b1); tick_bit(1'b1);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t5_cnt", 32'(vcnt - vb), 1);
      chk("t5_data", bus.data_out, 8'hC3);
      chk("t5_latency", 32'(vcyc - start), 14);

      // async reset mid-byte
      tick_bit(1'b1); tick_bit(1'b0); tick_bit(1'b1);
      reset = 1'b1;
      #1;
      chk("t5_rst_data", bus.data_out, 8'h00);
      chk("t5_rst_active", bus.active, 1'b0);
      chk("t5_rst_valid", bus.valid_out, 1'b0);
      chk("t5_rst_seen", bus.com_seen, 1'b0);

      // 16 non-COM bytes after lock
      do_reset();
      lock4();
      vb = vcnt;
      for (int i = 1; i <= 16; i++) send_byte(8'(i));
      chk("t6_cnt15", 32'(vcnt - vb), 15);
      chk("t6_active15", bus.active, 1'b1);
      tick_bit(1'b0); tick_bit(1'b0);
      chk("t6_cnt16", 32'(vcnt - vb), 16);
      chk("t6_data16", bus.data_out, 8'h10);
`ifdef SP_LOSS_OF_LOCK_EN
      chk("t6_active16", bus.active, 1'b0);
`else
      chk("t6_active16", bus.active, 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
